// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline widths and the decoded control bundle
// used by ID/EX, EX/MEM and MEM/WB.
package riscv_pipe_pkg;
   localparam int XLEN    = 32;
   localparam int ALUOP_W = 4;
   typedef struct packed {
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic               mem_to_reg;
      logic               alu_src;
      logic               branch;
      logic [ALUOP_W-1:0] alu_op;
   } ctrl_t;
   localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: decode-side inputs and registered ID/EX outputs;
// master is the decode/driver side, slave is the pipeline register.
interface id_ex_stage_reg_if;
   import riscv_pipe_pkg::*;
   logic               id_valid;
   logic [XLEN-1:0]    id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]         id_rs1, id_rs2, id_rd;
   logic               id_uses_rs1, id_uses_rs2;
   logic               id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUsrc, id_Branch;
   logic [ALUOP_W-1:0] id_ALUop;
   logic               ID_EX_valid;
   logic [XLEN-1:0]    ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
   logic [4:0]         ID_EX_Read_register1, ID_EX_Read_register2, ID_EX_Write_register;
   logic               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUsrc, ID_EX_Branch;
   logic [ALUOP_W-1:0] ID_EX_ALUop;
   logic               hazard_stall;
   modport master (
      output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
             id_uses_rs1, id_uses_rs2, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg,
             id_ALUsrc, id_Branch, id_ALUop,
      input  ID_EX_valid, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
             ID_EX_Read_register1, ID_EX_Read_register2, ID_EX_Write_register,
             ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUsrc,
             ID_EX_Branch, ID_EX_ALUop, hazard_stall
   );
   modport slave (
      input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
             id_uses_rs1, id_uses_rs2, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg,
             id_ALUsrc, id_Branch, id_ALUop,
      output ID_EX_valid, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
             ID_EX_Read_register1, ID_EX_Read_register2, ID_EX_Write_register,
             ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUsrc,
             ID_EX_Branch, ID_EX_ALUop, hazard_stall
   );
endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags an instruction in decode that reads the destination
// of a load currently in EX; x0 destinations never match.
module load_use_detect (
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic       id_valid,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       lu
);
   assign lu = ex_mem_read & (ex_rd != 5'd0) & id_valid &
               ((id_uses_rs1 & (ex_rd == id_rs1)) | (id_uses_rs2 & (ex_rd == id_rs2)));
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble, flush and stall.
// Define ID_EX_PERF_CNT_EN to add saturating perf_bubbles/perf_flushes counters.
module id_ex_stage_reg
   import riscv_pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_flush,
   input  logic              ext_stall,
   id_ex_stage_reg_if.slave  bus
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]       perf_bubbles,
   output logic [31:0]       perf_flushes
`endif
);
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      ctrl_t           ctrl;
   } stage_t;
   stage_t q, d;
   logic   lu;
   load_use_detect u_lud (
      .ex_mem_read (q.ctrl.mem_read),
      .ex_rd       (q.rd),
      .id_valid    (bus.id_valid),
      .id_uses_rs1 (bus.id_uses_rs1),
      .id_uses_rs2 (bus.id_uses_rs2),
      .id_rs1      (bus.id_rs1),
      .id_rs2      (bus.id_rs2),
      .lu          (lu)
   );
   // an invalid decode slot still carries its fields but can never act
   assign d = '{
      valid:    bus.id_valid,
      pc:       bus.id_pc,
      rs1_data: bus.id_rs1_data,
      rs2_data: bus.id_rs2_data,
      imm:      bus.id_imm,
      rs1:      bus.id_rs1,
      rs2:      bus.id_rs2,
      rd:       bus.id_rd,
      ctrl:     bus.id_valid ? ctrl_t'{bus.id_RegWrite, bus.id_MemRead, bus.id_MemWrite,
                                       bus.id_MemtoReg, bus.id_ALUsrc, bus.id_Branch,
                                       bus.id_ALUop} : CTRL_BUBBLE
   };
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         q <= '0;
      else if (ex_flush || (lu && !ext_stall))
         q <= '0;
      else if (!ext_stall)
         q <= d;
   assign bus.hazard_stall         = lu & ~ex_flush;
   assign bus.ID_EX_valid          = q.valid;
   assign bus.ID_EX_pc             = q.pc;
   assign bus.ID_EX_rs1_data       = q.rs1_data;
   assign bus.ID_EX_rs2_data       = q.rs2_data;
   assign bus.ID_EX_imm            = q.imm;
   assign bus.ID_EX_Read_register1 = q.rs1;
   assign bus.ID_EX_Read_register2 = q.rs2;
   assign bus.ID_EX_Write_register = q.rd;
   assign bus.ID_EX_RegWrite       = q.ctrl.reg_write;
   assign bus.ID_EX_MemRead        = q.ctrl.mem_read;
   assign bus.ID_EX_MemWrite       = q.ctrl.mem_write;
   assign bus.ID_EX_MemtoReg       = q.ctrl.mem_to_reg;
   assign bus.ID_EX_ALUsrc         = q.ctrl.alu_src;
   assign bus.ID_EX_Branch         = q.ctrl.branch;
   assign bus.ID_EX_ALUop          = q.ctrl.alu_op;
`ifdef ID_EX_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         perf_bubbles <= '0;
         perf_flushes <= '0;
      end else begin
         if (lu && !ex_flush && !ext_stall && perf_bubbles != '1)
            perf_bubbles <= perf_bubbles + 32'd1;
         if (ex_flush && perf_flushes != '1)
            perf_flushes <= perf_flushes + 32'd1;
      end
`endif
endmodule
